// File: rtl/quadrature_decoder.sv
// Quadrature decoder with input synchronizer, glitch filter and signed position counter.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - synchronous active-high reset
//   enable   - high allows count/dir/step updates (decoding keeps tracking when low)
//   clear    - one-cycle request to zero the position counter
//   err_clr  - request to clear the sticky error flag
//   a, b     - asynchronous quadrature phases
//   count    - signed WIDTH-bit position, wraps modulo 2^WIDTH
//   step     - one-cycle pulse per counted step, one cycle after count changes
//   dir      - direction of the most recent counted step (1 = forward)
//   error    - sticky flag, set when an accepted transition flips both phases
//
// Pipeline (FILTER = F): sync1 edge 0, sync2 edge 1, accept edge F+1,
// count edge F+2, step edge F+3.
module quadrature_decoder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FILTER = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             err_clr,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             error
);

  localparam logic [7:0] FiltLim = 8'(FILTER);

  // Position of a Gray state along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       cand_q, cand_d;
  logic [7:0]       stab_q, stab_d;
  logic [1:0]       acc_q, acc_d;
  logic             primed_q, primed_d;
  logic             ev_fwd_q, ev_fwd_d;
  logic             ev_rev_q, ev_rev_d;
  logic             ev_ill_q, ev_ill_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             error_q, error_d;

  logic       differs;
  logic [7:0] obs;
  logic       accept;
  logic [1:0] delta;

  always_comb begin
    // Until primed, any synchronized state counts as a new candidate.
    differs  = !primed_q || (sync2_q != acc_q);
    // Observations of the current candidate, including this cycle.
    obs      = ((stab_q != 8'd0) && (sync2_q == cand_q)) ? stab_q + 8'd1 : 8'd1;
    accept   = differs && (obs >= FiltLim);
    cand_d   = sync2_q;
    stab_d   = (!differs || accept) ? 8'd0 : obs;
    acc_d    = accept ? sync2_q : acc_q;
    primed_d = primed_q || accept;

    delta    = gray_idx(sync2_q) - gray_idx(acc_q);
    // A clear in the acceptance cycle consumes the transition.
    ev_fwd_d = accept && primed_q && !clear && (delta == 2'd1);
    ev_rev_d = accept && primed_q && !clear && (delta == 2'd3);
    ev_ill_d = accept && primed_q && (delta == 2'd2);
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    pend_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable && ev_fwd_q) begin
      count_d = count_q + 1'b1;
      dir_d   = 1'b1;
      pend_d  = 1'b1;
    end else if (enable && ev_rev_q) begin
      count_d = count_q - 1'b1;
      dir_d   = 1'b0;
      pend_d  = 1'b1;
    end
    step_d  = pend_q && enable && !clear;

    error_d = error_q;
    if (ev_ill_q) begin
      error_d = 1'b1;
    end else if (err_clr) begin
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      cand_q   <= 2'b00;
      stab_q   <= 8'd0;
      acc_q    <= 2'b00;
      primed_q <= 1'b0;
      ev_fwd_q <= 1'b0;
      ev_rev_q <= 1'b0;
      ev_ill_q <= 1'b0;
      pend_q   <= 1'b0;
      count_q  <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      sync1_q  <= {a, b};
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      acc_q    <= acc_d;
      primed_q <= primed_d;
      ev_fwd_q <= ev_fwd_d;
      ev_rev_q <= ev_rev_d;
      ev_ill_q <= ev_ill_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      error_q  <= error_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign error = error_q;

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter WIDTH, default 16: position counter width in bits (legal range 2..32).
REQ-002 Parameter FILTER, default 4: consecutive stable synchronized samples required to accept a new input state (legal range 1..255).
REQ-003 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: reset, synchronous to clk, active-high.
REQ-005 Port enable  input  1: high = count updates and step pulses permitted.
REQ-006 Port clear  input  1: synchronous one-cycle request to zero the position counter.
REQ-007 Port err_clr  input  1: synchronous request to clear the error flag.
REQ-008 Port a  input  1: quadrature phase A, asynchronous to clk.
REQ-009 Port b  input  1: quadrature phase B, asynchronous to clk.
REQ-010 Port count  output  WIDTH: signed two's-complement position, registered.
REQ-011 Port step  output  1: one-cycle pulse per accepted count change, registered.
REQ-012 Port dir  output  1: direction of the most recent accepted step (1 = forward, 0 = reverse), registered.
REQ-013 Port error  output  1: sticky illegal-transition flag, registered.

Function
REQ-014 a and b SHALL each pass through a two-flop synchronizer before any other use.
REQ-015 Input state SHALL be the 2-bit Gray value {a,b} taken from the synchronizer outputs.
REQ-016 Filter: a synchronized state that differs from the accepted state SHALL become accepted only after it has been observed for FILTER consecutive cycles; any change in the synchronized state SHALL restart the stability count at zero.
REQ-017 A synchronized state equal to the accepted state SHALL hold the stability count at zero.
REQ-018 Forward sequence SHALL be 00 -> 01 -> 11 -> 10 -> 00; each accepted forward transition SHALL increment count by 1 and set dir = 1.
REQ-019 Reverse sequence SHALL be 00 -> 10 -> 11 -> 01 -> 00; each accepted reverse transition SHALL decrement count by 1 and set dir = 0.
REQ-020 Accepted transition changing both bits (00<->11, 01<->10) SHALL set error, leave count and dir unchanged, and raise no step.
REQ-021 step SHALL be high exactly one cycle, in the cycle after count takes its new value.
REQ-022 Latency: step SHALL assert FILTER+3 cycles after the clock edge at which the first synchronizer flop first samples the new pin value, the pin being held stable throughout.
REQ-023 count SHALL wrap modulo 2^WIDTH: max positive + 1 -> most-negative value; 0 - 1 -> all ones.
REQ-024 enable low: synchronizer, filter and accepted state SHALL keep tracking; count, dir and step SHALL not change (step held low); errors SHALL still be flagged.
REQ-025 clear high SHALL load count = 0 next cycle and suppress any step that cycle; clear overrides a simultaneous accepted transition (that transition is consumed, not counted later).
REQ-026 err_clr high SHALL clear error next cycle unless an illegal transition is accepted in the same cycle, in which case error stays 1.
REQ-027 First accepted state after reset SHALL prime the decoder only: no step, no count change, no error.

Reset
REQ-028 While reset is high on a clk edge: count = 0, step = 0, dir = 0, error = 0, synchronizer flops = 0, stability count = 0, decoder unprimed.
REQ-029 reset asserted mid-filter or mid-transition SHALL discard the pending candidate; reset SHALL override enable, clear and err_clr.

Verification
REQ-030 Reset, pins held 00 for 20 cycles -> prime only; count = 0, step never high, error = 0.
REQ-031 Prime at 00, then drive 01, 11, 10, 00, each held 10 cycles (FILTER=4) -> four step pulses, count = 4, dir = 1; first step exactly 7 cycles after the 01 sample edge.
REQ-032 From count = 0, one reverse step (00 -> 10) -> count = all ones (-1), dir = 0; with WIDTH=4 and count = 7, one forward step -> count = 8 (-8).
REQ-033 Glitch: pin toggled to 01 for 3 cycles then back to 00 (FILTER=4) -> no accept, no step, count unchanged.
REQ-034 Prime at 00, drive 11 held 10 cycles -> error = 1, count unchanged, no step; err_clr pulse -> error = 0 next cycle.
REQ-035 clear asserted in the same cycle a forward transition is accepted, with enable low on a later step -> count = 0, no step; later step leaves count = 0, no step, but accepted state advances.
